// File: rtl/iob_fifo_sync_asym_if.sv
// iob_fifo_sync_asym_if: write/read handshake bundle for the asymmetric-width
// single-clock FIFO. The master modport is the user side that produces writes
// and consumes reads; the slave modport is the FIFO itself.
interface iob_fifo_sync_asym_if #(
   parameter int W_DATA_W = 32,
   parameter int R_DATA_W = 8,
   parameter int ADDR_W   = 4
) ();

   logic                w_en;
   logic [W_DATA_W-1:0] w_data;
   logic                w_full;
   logic                r_en;
   logic [R_DATA_W-1:0] r_data;
   logic                r_empty;
   logic [ADDR_W:0]     level;

   modport master (
      output w_en,
      output w_data,
      output r_en,
      input  w_full,
      input  r_data,
      input  r_empty,
      input  level
   );

   modport slave (
      input  w_en,
      input  w_data,
      input  r_en,
      output w_full,
      output r_data,
      output r_empty,
      output level
   );

endinterface

// File: rtl/iob_fifo_sync_asym.sv
// iob_fifo_sync_asym: single-clock FIFO with independent write and read word
// widths (power-of-two ratio either way). Storage is a register array of
// DEPTH = 2^ADDR_W narrow words; every entry is usable because the registered
// occupancy counter, not the pointers, decides full and empty.
//
// Build option: define IOB_FIFO_SYNC_ASYM_FWFT_EN for first-word fall-through
// (r_data shows the head word combinationally, zero read latency). Without it
// r_data is registered at the edge that accepts a read and holds until the
// next accepted read.
module iob_fifo_sync_asym #(
   parameter int W_DATA_W = 32,
   parameter int R_DATA_W = 8,
   parameter int ADDR_W   = 4
) (
   input logic                clk,
   input logic                rst,
   iob_fifo_sync_asym_if.slave bus
);

   // Geometry. Pointers count narrow words; one wide access spans a
   // contiguous, naturally aligned group of narrow entries.
   localparam int MIN_W   = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
   localparam int W_RATIO = W_DATA_W / MIN_W;
   localparam int R_RATIO = R_DATA_W / MIN_W;
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int LVL_W   = ADDR_W + 1;

   // Step sizes and flag thresholds sized to the counters they act on.
   // A ratio equal to DEPTH truncates to a zero pointer step, which is the
   // correct modulo-DEPTH advance.
   localparam logic [ADDR_W-1:0] W_PTR_STEP = ADDR_W'(W_RATIO);
   localparam logic [ADDR_W-1:0] R_PTR_STEP = ADDR_W'(R_RATIO);
   localparam logic [LVL_W-1:0]  W_LVL_STEP = LVL_W'(W_RATIO);
   localparam logic [LVL_W-1:0]  R_LVL_STEP = LVL_W'(R_RATIO);
   localparam logic [LVL_W-1:0]  FULL_THR   = LVL_W'(DEPTH - W_RATIO);

   // Storage and state.
   logic [MIN_W-1:0]    mem_r [DEPTH];
   logic [ADDR_W-1:0]   wptr_r;
   logic [ADDR_W-1:0]   rptr_r;
   logic [LVL_W-1:0]    level_r;
   logic                w_full_r;
   logic                r_empty_r;

   // Per-cycle decisions.
   logic                wacc_s;
   logic                racc_s;
   logic [LVL_W-1:0]    level_next_s;
   logic [R_DATA_W-1:0] rd_word_s;

   // Acceptance uses only the registered flags, so a same-cycle read never
   // makes room for a write and a same-cycle write never feeds a read.
   always_comb begin
      wacc_s = 1'b0;
      racc_s = 1'b0;
      if (bus.w_en && !w_full_r) begin
         wacc_s = 1'b1;
      end else begin
         wacc_s = 1'b0;
      end
      if (bus.r_en && !r_empty_r) begin
         racc_s = 1'b1;
      end else begin
         racc_s = 1'b0;
      end
   end

   // Next occupancy in narrow words. An accepted write implies
   // level <= DEPTH - W_RATIO, so the sum never exceeds DEPTH.
   always_comb begin
      level_next_s = level_r;
      case ({wacc_s, racc_s})
         2'b11:   level_next_s = level_r + W_LVL_STEP - R_LVL_STEP;
         2'b10:   level_next_s = level_r + W_LVL_STEP;
         2'b01:   level_next_s = level_r - R_LVL_STEP;
         2'b00:   level_next_s = level_r;
         default: level_next_s = level_r;
      endcase
   end

   // Pointers, occupancy and flags; flags are derived from the next level so
   // they change on the same edge that performs the operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_r    <= {ADDR_W{1'b0}};
         rptr_r    <= {ADDR_W{1'b0}};
         level_r   <= {LVL_W{1'b0}};
         w_full_r  <= 1'b0;
         r_empty_r <= 1'b1;
      end else begin
         if (wacc_s) begin
            wptr_r <= wptr_r + W_PTR_STEP;
         end
         if (racc_s) begin
            rptr_r <= rptr_r + R_PTR_STEP;
         end
         level_r   <= level_next_s;
         w_full_r  <= (level_next_s > FULL_THR);
         r_empty_r <= (level_next_s < R_LVL_STEP);
      end
   end

   // Storage write: split the write word into narrow sub-words, least
   // significant first at the lowest address. Contents are never reset.
   always_ff @(posedge clk) begin
      if (wacc_s) begin
         for (int i = 0; i < W_RATIO; i++) begin
            mem_r[wptr_r + ADDR_W'(i)] <= bus.w_data[i*MIN_W +: MIN_W];
         end
      end
   end

   // Head read word: gather R_RATIO narrow entries from the read pointer,
   // the oldest one in the least significant position.
   always_comb begin
      rd_word_s = {R_DATA_W{1'b0}};
      for (int i = 0; i < R_RATIO; i++) begin
         rd_word_s[i*MIN_W +: MIN_W] = mem_r[rptr_r + ADDR_W'(i)];
      end
   end

`ifdef IOB_FIFO_SYNC_ASYM_FWFT_EN
   // Fall-through: the head word is presented directly; it is meaningless
   // while r_empty is high.
   assign bus.r_data = rd_word_s;
`else
   logic [R_DATA_W-1:0] r_data_r;

   // Registered read data: captured only on an accepted read, otherwise held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_r <= {R_DATA_W{1'b0}};
      end else if (racc_s) begin
         r_data_r <= rd_word_s;
      end
   end

   assign bus.r_data = r_data_r;
`endif

   assign bus.level   = level_r;
   assign bus.w_full  = w_full_r;
   assign bus.r_empty = r_empty_r;

endmodule
